// File: rtl/ebpf_alu_divider_if.sv
`default_nettype none
// ============================================================================
// Module   : ebpf_alu_divider_if
// Brief    : Request/response bundle between the execute-stage controller
//            and the eBPF multi-cycle divider. signed_op exists only when
//            EBPF_DIV_SIGNED_EN is defined.
// Revision : 1.0
// ============================================================================
interface ebpf_alu_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef EBPF_DIV_SIGNED_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
`ifdef EBPF_DIV_SIGNED_EN
        output signed_op,
`endif
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
`ifdef EBPF_DIV_SIGNED_EN
        input  signed_op,
`endif
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/ebpf_alu_divider.sv
`default_nettype none
// ============================================================================
// Module   : ebpf_alu_divider
// Brief    : Multi-cycle restoring divider for the eBPF DIV/MOD opcodes.
//            Define EBPF_DIV_SIGNED_EN to add signed division via signed_op.
// Revision : 1.0
// ============================================================================
module ebpf_alu_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    ebpf_alu_divider_if.slave      bus
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ZERO = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_busy;
    logic               w_done;
    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_div;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;

    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic [WIDTH-1:0]   w_mag_dividend;
    logic [WIDTH-1:0]   w_mag_divisor;
    logic               w_neg_q;
    logic               w_neg_r;

    logic [WIDTH:0]     w_trial;
    logic               w_fits;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_quo_final;
    logic [WIDTH-1:0]   w_rem_final;

    // A divide-by-zero request parks in S_ZERO for one cycle so its done
    // pulse lands one edge after acceptance; only IDLE and DONE accept work.
    assign w_accept   = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_div_zero = (bus.divisor == '0);
    assign w_last     = (r_cnt == '0);

`ifdef EBPF_DIV_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;

    assign w_dvd_neg      = bus.signed_op && bus.dividend[WIDTH-1];
    assign w_dvs_neg      = bus.signed_op && bus.divisor[WIDTH-1];
    // The most-negative dividend keeps its bit pattern as a magnitude,
    // which is exactly what the overflow case needs.
    assign w_mag_dividend = w_dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_mag_divisor  = w_dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    assign w_neg_q        = w_dvd_neg ^ w_dvs_neg;
    assign w_neg_r        = w_dvd_neg;
`else
    assign w_mag_dividend = bus.dividend;
    assign w_mag_divisor  = bus.divisor;
    assign w_neg_q        = 1'b0;
    assign w_neg_r        = 1'b0;
`endif

    // Partial remainder stays below the divisor, so the top bit of the
    // WIDTH+1-bit trial difference is a reliable borrow flag.
    assign w_trial     = {r_rem, r_q[WIDTH-1]} - {1'b0, r_div};
    assign w_fits      = ~w_trial[WIDTH];
    assign w_rem_next  = w_fits ? w_trial[WIDTH-1:0] : {r_rem[WIDTH-2:0], r_q[WIDTH-1]};
    assign w_q_next    = {r_q[WIDTH-2:0], w_fits};
    assign w_quo_final = r_neg_q ? (~w_q_next + 1'b1)   : w_q_next;
    assign w_rem_final = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_div_zero ? S_ZERO : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_ZERO: begin
                w_state_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (w_accept) begin
                    w_state_next = w_div_zero ? S_ZERO : S_RUN;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem         <= '0;
            r_q           <= '0;
            r_div         <= '0;
            r_cnt         <= '0;
            r_neg_q       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quotient    <= '0;
                r_remainder   <= bus.dividend;
                r_div_by_zero <= 1'b1;
            end else begin
                r_rem         <= '0;
                r_q           <= w_mag_dividend;
                r_div         <= w_mag_divisor;
                r_cnt         <= c_CNT_LAST;
                r_neg_q       <= w_neg_q;
                r_neg_r       <= w_neg_r;
                r_div_by_zero <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_rem_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - c_CNT_ONE;
            if (w_last) begin
                r_quotient  <= w_quo_final;
                r_remainder <= w_rem_final;
            end
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire
